// File: rtl/fp_cfg_sequencer.sv
// Double-banked per-stage configuration for the filter pipeline; shadow swaps into active once in-flight data drains.
// Latency: commit_ack 3 cycles after commit_req with an empty pipe, up to PIPE_LAT+3 with beats in flight.
// Backpressure: cfg_ready and in_ready both drop for the whole DRAIN/SWAP window.
module fp_cfg_sequencer #(
    parameter int STAGES   = 8,
    parameter int CFG_W    = 64,
    parameter int PIPE_LAT = 8,
    parameter int SEL_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [SEL_W-1:0]        cfg_stage,
    input  logic [CFG_W-1:0]        cfg_data,
    input  logic                    commit_req,
    output logic                    commit_ack,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [STAGES*CFG_W-1:0] active_cfg,
    output logic [STAGES-1:0]       dirty,
    output logic                    busy,
    output logic                    cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PIPE_LAT-1:0] inflight;
    logic                drained;
    logic                in_acc;
    logic                cfg_acc;
    logic                stage_ok;
    logic                commit_start;
    logic                req_block;
    logic [CFG_W-1:0]    shadow [STAGES];

    assign in_acc       = in_valid && in_ready;
    assign cfg_acc      = cfg_valid && cfg_ready;
    assign drained      = (inflight == '0);
    assign stage_ok     = (32'(cfg_stage) < 32'(STAGES));
    // commit_req is a level; it must fall once after an ack before it can start another commit
    assign commit_start = commit_req && !req_block;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit_start) state_nxt = DRAIN;
            DRAIN:   if (drained)      state_nxt = SWAP;
            SWAP:                      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;
        if (state == IDLE) begin
            cfg_ready = 1'b1;
            in_ready  = 1'b1;
            busy      = 1'b0;
        end
    end

    // One bit per pipeline slot; a beat accepted this cycle retires PIPE_LAT cycles later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            inflight <= (inflight << 1) | PIPE_LAT'(in_acc);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) begin
                shadow[s] <= '0;
            end
            dirty <= '0;
        end else if (state == SWAP) begin
            dirty <= '0;
        end else if (cfg_acc && stage_ok) begin
            for (int s = 0; s < STAGES; s++) begin
                if (cfg_stage == SEL_W'(s)) begin
                    shadow[s] <= cfg_data;
                    dirty[s]  <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_cfg <= '0;
        end else if (state == SWAP) begin
            for (int s = 0; s < STAGES; s++) begin
                if (dirty[s]) begin
                    active_cfg[s*CFG_W +: CFG_W] <= shadow[s];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_ack <= 1'b0;
            req_block  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            commit_ack <= (state == SWAP);
            if (state == SWAP) begin
                req_block <= 1'b1;
            end else if (!commit_req) begin
                req_block <= 1'b0;
            end
            if (cfg_acc && !stage_ok) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_cfg_sequencer.sv
// Scoreboard bench for fp_cfg_sequencer: commits push the expected ack cycle and active_cfg,
// monitors pop on commit_ack and also hold active_cfg stable on every other cycle.
module tb_fp_cfg_sequencer;

    localparam int PL = 8;

    typedef struct packed {
        int           cyc;
        logic [511:0] cfg;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb  [$];
    exp_t sb6 [$];
    logic [511:0] mdl;
    logic [511:0] mdl6;
    logic [511:0] exp_cur;
    logic [511:0] exp6;

    // main instance, 8 stages
    logic          cfg_valid, cfg_ready, commit_req, commit_ack, in_valid, in_ready, busy, cfg_err;
    logic [2:0]    cfg_stage;
    logic [63:0]   cfg_data;
    logic [511:0]  active_cfg;
    logic [7:0]    dirty;

    // second instance, 6 stages with a 3-bit index
    logic          c6_valid, c6_ready, c6_req, c6_ack, c6_in_ready, c6_busy, c6_err;
    logic [2:0]    c6_stage;
    logic [63:0]   c6_data;
    logic [383:0]  c6_active;
    logic [5:0]    c6_dirty;

    fp_cfg_sequencer #(.STAGES(8), .CFG_W(64), .PIPE_LAT(PL), .SEL_W(3)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_stage(cfg_stage), .cfg_data(cfg_data),
        .commit_req(commit_req), .commit_ack(commit_ack),
        .in_valid(in_valid), .in_ready(in_ready),
        .active_cfg(active_cfg), .dirty(dirty), .busy(busy), .cfg_err(cfg_err)
    );

    fp_cfg_sequencer #(.STAGES(6), .CFG_W(64), .PIPE_LAT(PL), .SEL_W(3)) dut6 (
        .clk(clk), .rst(rst),
        .cfg_valid(c6_valid), .cfg_ready(c6_ready), .cfg_stage(c6_stage), .cfg_data(c6_data),
        .commit_req(c6_req), .commit_ack(c6_ack),
        .in_valid(1'b0), .in_ready(c6_in_ready),
        .active_cfg(c6_active), .dirty(c6_dirty), .busy(c6_busy), .cfg_err(c6_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitors
    always @(negedge clk) begin
        if (!rst) begin
            mdl = '0;
        end else if (commit_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 512'(cyc), 512'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_cycle", 512'(cyc), 512'(e.cyc));
                chk("ack_active", active_cfg, e.cfg);
                mdl = e.cfg;
            end
        end else begin
            chk("active_stable", active_cfg, mdl);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            mdl6 = '0;
        end else if (c6_ack) begin
            if (sb6.size() == 0) begin
                chk("unexpected_ack6", 512'(cyc), 512'(0));
            end else begin
                exp_t e;
                e = sb6.pop_front();
                chk("ack6_cycle", 512'(cyc), 512'(e.cyc));
                chk("ack6_active", 512'(c6_active), e.cfg);
                mdl6 = e.cfg;
            end
        end else begin
            chk("active6_stable", 512'(c6_active), mdl6);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] st, input logic [63:0] d);
        cfg_valid = 1'b1;
        cfg_stage = st;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) chk(name, 512'(busy), 512'(0));
        tick();
    endtask

    // req held for hold cycles; ack expected lat cycles after the first req cycle
    task automatic do_commit(input logic [511:0] exp, input int lat, input int hold);
        commit_req = 1'b1;
        sb.push_back('{cyc: cyc + lat, cfg: exp});
        repeat (hold) tick();
        commit_req = 1'b0;
        wait_idle("commit_timeout");
        tick();
    endtask

    task automatic commit6(input logic [511:0] exp);
        int guard;
        c6_req = 1'b1;
        sb6.push_back('{cyc: cyc + 3, cfg: exp});
        tick();
        c6_req = 1'b0;
        guard = 0;
        @(negedge clk);
        while (c6_busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) chk("commit6_timeout", 512'(c6_busy), 512'(0));
        tick();
        tick();
    endtask

    initial begin
        int t;
        int guard;
        cyc = 0; checks = 0; errors = 0;
        mdl = '0; mdl6 = '0; exp_cur = '0; exp6 = '0;
        rst = 1'b0;
        cfg_valid = 1'b0; cfg_stage = '0; cfg_data = '0; commit_req = 1'b0; in_valid = 1'b0;
        c6_valid = 1'b0; c6_stage = '0; c6_data = '0; c6_req = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_ack", 512'(commit_ack), 512'(0));
        chk("rst_err", 512'(cfg_err), 512'(0));
        chk("rst_dirty", 512'(dirty), 512'(0));
        chk("rst_active", active_cfg, 512'(0));
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rel_cfg_ready", 512'(cfg_ready), 512'(1));
        chk("rel_in_ready", 512'(in_ready), 512'(1));
        tick();

        // stage2 / stage7 then an empty-pipe commit
        wr(3'd2, 64'hA5);
        wr(3'd7, 64'h3C);
        @(negedge clk);
        chk("dirty_84", 512'(dirty), 512'h84);
        tick();
        exp_cur[2*64 +: 64] = 64'hA5;
        exp_cur[7*64 +: 64] = 64'h3C;
        do_commit(exp_cur, 3, 1);
        @(negedge clk);
        chk("dirty_clear", 512'(dirty), 512'(0));
        tick();

        // commit with beats at t-1 and t, plus a write held during DRAIN
        wr(3'd1, 64'h1111);
        exp_cur[1*64 +: 64] = 64'h1111;
        in_valid = 1'b1;
        tick();
        t = cyc;
        commit_req = 1'b1;
        sb.push_back('{cyc: t + PL + 3, cfg: exp_cur});
        tick();
        in_valid   = 1'b0;
        commit_req = 1'b0;
        cfg_valid  = 1'b1;
        cfg_stage  = 3'd4;
        cfg_data   = 64'h44;
        @(negedge clk);
        chk("drain_in_ready", 512'(in_ready), 512'(0));
        chk("drain_cfg_ready", 512'(cfg_ready), 512'(0));
        repeat (4) @(negedge clk);
        chk("drain_busy", 512'(busy), 512'(1));
        guard = 0;
        while (!cfg_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) chk("cfg_accept_timeout", 512'(cfg_ready), 512'(1));
        chk("cfg_accept_cycle", 512'(cyc), 512'(t + PL + 3));
        tick();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("dirty_only_4", 512'(dirty), 512'h10);
        tick();
        exp_cur[4*64 +: 64] = 64'h44;
        do_commit(exp_cur, 3, 1);

        // overwrite stage 0, then a write-free commit with req held past the ack
        wr(3'd0, 64'h11);
        wr(3'd0, 64'h22);
        @(negedge clk);
        chk("dirty_01", 512'(dirty), 512'h01);
        tick();
        exp_cur[0*64 +: 64] = 64'h22;
        do_commit(exp_cur, 3, 1);
        do_commit(exp_cur, 3, 8);

        // write and commit in the same cycle
        cfg_valid = 1'b1;
        cfg_stage = 3'd3;
        cfg_data  = 64'h33;
        exp_cur[3*64 +: 64] = 64'h33;
        commit_req = 1'b1;
        sb.push_back('{cyc: cyc + 3, cfg: exp_cur});
        tick();
        cfg_valid  = 1'b0;
        commit_req = 1'b0;
        wait_idle("same_cycle_timeout");
        tick();

        // out-of-range stage on the 6-stage instance
        c6_valid = 1'b1; c6_stage = 3'd2; c6_data = 64'hBEEF;
        tick();
        c6_valid = 1'b0;
        exp6[2*64 +: 64] = 64'hBEEF;
        commit6(exp6);
        c6_valid = 1'b1; c6_stage = 3'd7; c6_data = 64'hFF;
        tick();
        c6_valid = 1'b0;
        @(negedge clk);
        chk("err6_set", 512'(c6_err), 512'(1));
        chk("err6_no_dirty", 512'(c6_dirty), 512'(0));
        repeat (3) tick();
        @(negedge clk);
        chk("err6_sticky", 512'(c6_err), 512'(1));
        chk("err8_clear", 512'(cfg_err), 512'(0));
        tick();
        commit6(exp6);
        chk("err6_after_commit", 512'(c6_err), 512'(1));

        // reset while draining
        wr(3'd5, 64'h55);
        in_valid   = 1'b1;
        commit_req = 1'b1;
        tick();
        in_valid   = 1'b0;
        commit_req = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("pre_rst_busy", 512'(busy), 512'(1));
        chk("pre_rst_dirty", 512'(dirty), 512'h20);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_ack", 512'(commit_ack), 512'(0));
        chk("mid_rst_busy", 512'(busy), 512'(0));
        chk("mid_rst_active", active_cfg, 512'(0));
        chk("mid_rst_dirty", 512'(dirty), 512'(0));
        repeat (2) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 512'(in_ready), 512'(1));
        chk("post_rst_busy", 512'(busy), 512'(0));
        repeat (PL + 6) tick();

        chk("sb_empty", 512'(sb.size()), 512'(0));
        chk("sb6_empty", 512'(sb6.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
